// File: rtl/full_subtractor.sv
// Single-bit full subtractor with registered outputs.
// Chain mode feeds the stored borrow back for LSB-first serial words.
module full_subtractor #(
    parameter int SERIAL_WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    output logic Bout,
    output logic Diff,
    input  logic A,
    input  logic B,
    input  logic Bin,
    input  logic en,
    input  logic chain,
    output logic valid,
    output logic word_done
);

    localparam int CW = (SERIAL_WIDTH > 2) ? $clog2(SERIAL_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(SERIAL_WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic          bin_eff;
    logic          d;
    logic          bo;
    logic          at_last;
    logic [CW-1:0] cnt;

    // Borrow source select and the combinational subtractor core.
    always_comb begin
        bin_eff = chain ? Bout : Bin;
        d       = A ^ B ^ bin_eff;
        bo      = (~A & B) | (~(A ^ B) & bin_eff);
        at_last = (cnt == LAST);
    end

    // Result registers: capture on accepted beats, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Diff  <= 1'b0;
            Bout  <= 1'b0;
            valid <= 1'b0;
        end else if (en) begin
            Diff  <= d;
            Bout  <= bo;
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

    // Serial position counter and end-of-word pulse.
    // A non-chained beat is the LSB, so the next position is 1.
    // A chained beat from position 0 simply starts counting at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            word_done <= 1'b0;
        end else if (en && !chain) begin
            cnt       <= ONE;
            word_done <= 1'b0;
        end else if (en && chain && at_last) begin
            cnt       <= '0;
            word_done <= 1'b1;
        end else if (en && chain) begin
            cnt       <= cnt + ONE;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor (SERIAL_WIDTH = 4).
// Directed steps followed by random beats against an arithmetic model.
module tb_full_subtractor;

    localparam int SW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic A     = 1'b0;
    logic B     = 1'b0;
    logic Bin   = 1'b0;
    logic en    = 1'b0;
    logic chain = 1'b0;
    logic Bout;
    logic Diff;
    logic valid;
    logic word_done;

    int checks = 0;
    int errors = 0;
    string ctx = "init";

    // Reference state: last result, and how many bits of the
    // current serial word have been accepted since its LSB.
    bit m_bout  = 1'b0;
    bit m_diff  = 1'b0;
    bit m_valid = 1'b0;
    bit m_done  = 1'b0;
    int m_bits  = 0;

    full_subtractor #(.SERIAL_WIDTH(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Bout      (Bout),
        .Diff      (Diff),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .en        (en),
        .chain     (chain),
        .valid     (valid),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, update the model,
    // then compare just after the rising edge.
    task automatic beat(input bit r, input bit e, input bit c,
                        input bit a, input bit b, input bit bi);
        bit be;
        int res;
        @(negedge clk);
        rst_n = r;
        en    = e;
        chain = c;
        A     = a;
        B     = b;
        Bin   = bi;
        @(posedge clk);
        #1;
        if (!r) begin
            m_bout  = 0;
            m_diff  = 0;
            m_valid = 0;
            m_done  = 0;
            m_bits  = 0;
        end else if (e) begin
            be      = c ? m_bout : bi;
            res     = int'(a) - int'(b) - int'(be);
            m_diff  = res[0];
            m_bout  = (res < 0);
            m_valid = 1;
            m_bits  = c ? m_bits + 1 : 1;
            m_done  = c && (m_bits == SW);
            if (m_bits == SW) m_bits = 0;
        end else begin
            m_valid = 0;
            m_done  = 0;
        end
        check({ctx, ".diff"}, 32'(Diff), 32'(m_diff));
        check({ctx, ".bout"}, 32'(Bout), 32'(m_bout));
        check({ctx, ".valid"}, 32'(valid), 32'(m_valid));
        check({ctx, ".done"}, 32'(word_done), 32'(m_done));
    endtask

    task automatic idle_beat();
        beat(1'b1, 1'b0, 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom));
    endtask

    // Serial word, LSB first, with an optional en gap before bit gap_at.
    task automatic do_word(input int a, input int b, input int bi,
                           input int gap_at, input int gap_len);
        int diff;
        int exp;
        int dones;
        diff  = 0;
        dones = 0;
        for (int i = 0; i < SW; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) idle_beat();
            end
            beat(1'b1, 1'b1, i != 0, 1'((a >> i) & 1), 1'((b >> i) & 1),
                 (i == 0) ? 1'(bi) : 1'($urandom));
            diff  = diff | (int'(Diff) << i);
            dones = dones + int'(word_done);
        end
        exp = (a - b - bi) & ((1 << SW) - 1);
        check({ctx, ".word"}, 32'(diff), 32'(exp));
        check({ctx, ".borrow"}, 32'(Bout), 32'(a < b + bi));
        check({ctx, ".ndone"}, 32'(dones), 32'd1);
        check({ctx, ".lastdone"}, 32'(word_done), 32'd1);
    endtask

    logic [1:0] tt [8];

    initial begin
        tt = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

        ctx = "reset";
        beat(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        beat(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("reset.all", 32'({Diff, Bout, valid, word_done}), 32'd0);

        ctx = "truth";
        for (int v = 0; v < 8; v++) begin
            beat(1'b1, 1'b1, 1'b0, 1'(v >> 2), 1'(v >> 1), 1'(v));
            check($sformatf("truth%0d", v), 32'({Bout, Diff}), 32'(tt[v]));
            check($sformatf("truth%0d.v", v), 32'(valid), 32'd1);
        end

        ctx = "hold";
        beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            beat(1'b1, 1'b0, 1'b0, 1'(k), 1'(k + 1), 1'(k));
            check("hold.out", 32'({Bout, Diff, valid}), 32'b110);
        end

        ctx = "w5m3";
        do_word(5, 3, 0, -1, 0);
        check("w5m3.b", 32'(Bout), 32'd0);
        ctx = "w3m5";
        do_word(3, 5, 0, -1, 0);
        check("w3m5.b", 32'(Bout), 32'd1);
        ctx = "gap";
        do_word(5, 3, 0, 2, 2);

        ctx = "midrst";
        beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("midrst.clr", 32'({Diff, Bout, valid, word_done}), 32'd0);
        do_word(9, 6, 0, -1, 0);

        ctx = "rwords";
        for (int n = 0; n < 20; n++) begin
            do_word(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                    int'($urandom_range(1, 0)),
                    int'($urandom_range(SW, 1)), int'($urandom_range(2, 0)));
        end

        ctx = "rbeats";
        for (int n = 0; n < 300; n++) begin
            beat($urandom_range(19, 0) != 0, $urandom_range(3, 0) != 0,
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_subtractor.md
# full_subtractor

Single-bit full subtractor cell for the 32-bit RISC ALU datapath, with registered outputs. It computes A − B − Bin and produces a difference bit and a borrow-out. A chain mode feeds the registered borrow back as the next borrow-in, so one instance performs LSB-first bit-serial subtraction of SERIAL_WIDTH-bit words. A word-complete pulse marks the end of each serial word.

## Interface
Parameters:
- SERIAL_WIDTH, 32, bits per serial word in chain mode; legal range 2..64.

Ports (positional order after clock/reset is Bout, Diff, A, B, Bin, then the added controls):
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
- Bout  output  1  registered borrow-out.
- Diff  output  1  registered difference bit.
- A  input  1  minuend bit.
- B  input  1  subtrahend bit.
- Bin  input  1  external borrow-in.
- en  input  1  accept A/B/Bin this cycle.
- chain  input  1  1 = use the registered Bout as borrow-in instead of Bin.
- valid  output  1  Diff/Bout updated by the previous accepted beat.
- word_done  output  1  one-cycle pulse: last bit of a serial word produced.

## Operation
- Effective borrow-in: bin_eff = chain ? Bout(reg) : Bin.
- Core equations (combinational):
  - d = A ^ B ^ bin_eff
  - bo = (~A & B) | (~(A ^ B) & bin_eff)
- Full truth table, as A B bin_eff -> Bout Diff:
  - 000 -> 0 0
  - 001 -> 1 1
  - 010 -> 1 1
  - 011 -> 1 0
  - 100 -> 0 1
  - 101 -> 0 0
  - 110 -> 0 0
  - 111 -> 1 1
- en=1: on the clock edge, Diff <= d, Bout <= bo, valid <= 1.
- en=0: Diff and Bout hold their values; valid <= 0; the bit counter holds.
- Bit counter (range 0..SERIAL_WIDTH−1) tracks serial position:
  - en & ~chain: counter <= 1. This beat is the LSB of a word and uses the external Bin.
  - en & chain: counter increments.
  - When an accepted chain beat has counter == SERIAL_WIDTH−1: word_done <= 1 for one cycle and counter <= 0.
  - chain=1 with counter == 0 (no LSB seen yet) is legal. It uses the stored Bout and starts a new count at 1; word_done is not asserted on that beat.
- Multi-bit subtraction protocol: present bit 0 with chain=0 and Bin=0 (or an external borrow), then bits 1..N−1 with chain=1 on consecutive or gapped en beats. After the last bit, the final Bout is the word borrow: 1 iff A < B + borrow-in, unsigned.
- en gaps inside a word preserve both the chain state and the counter.

## Timing
- Reset values while rst_n=0 at a clock edge: Diff=0, Bout=0, valid=0, word_done=0, counter=0.
- Reset takes priority over en.
- Reset in the middle of a serial word discards the word. The next word must restart with chain=0.
- Latency: 1 cycle from the en edge to Diff/Bout/valid. Throughput: 1 bit per cycle.
- word_done is asserted in the same cycle as valid for the final bit.
- No combinational path from inputs to outputs; all outputs are registers.
- Inputs are sampled only on rising clk edges where en=1.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with en=1, A=1, B=1, Bin=1 -> Diff=0, Bout=0, valid=0, word_done=0 throughout.
- Exhaustive truth table: chain=0, en=1, sweep A,B,Bin through 000..111 on successive cycles -> one cycle later Bout/Diff = 00, 11, 11, 10, 01, 00, 00, 11; valid=1 on each.
- Hold: after A=0, B=1, Bin=0 (Bout=1, Diff=1), drop en for 3 cycles while toggling inputs -> outputs stay 1/1 and valid=0.
- Serial word, with SERIAL_WIDTH=4:
  - 5 − 3: bits LSB-first A=1,0,1,0; B=1,1,0,0; first beat chain=0, Bin=0, rest chain=1 -> Diff sequence 0,1,0,0 (=2); final Bout=0; word_done on the 4th result only.
  - 3 − 5: A=1,1,0,0; B=1,0,1,0 -> Diff sequence 0,1,1,1 (=14); final Bout=1.
- Gapped chain: repeat 5 − 3 with en=0 for 2 cycles between bits 1 and 2 -> identical results, and word_done still after the 4th accepted bit.
- Mid-word reset: assert rst_n=0 after bit 2 of a word, then start a fresh 4-bit word -> outputs cleared, no word_done; new word produces a correct result and word_done after its own 4 bits.
